// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed 8-digit scan with blanking, capture and active-low enables.
// Define DIGIT_SCAN_LZB_EN to enable leading-zero blanking.
module digit_scan_ctrl #(
    parameter int PRESCALE   = 50000,
    parameter int BLANK      = 16,
    parameter int NUM_DIGITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       mux_s2,
    output logic       mux_s1,
    output logic       mux_s0,
    input  logic [3:0] mux_f,
    output logic [7:0] an_n,
    output logic [3:0] digit_val,
    output logic       digit_valid,
    output logic       frame_start
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [2:0] IDX_TOP = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d, sel;
    logic [3:0]    val_d;
    logic          fs_d, nz, nz_d, dark, dark_d, lit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= IDX_TOP;
            digit_val   <= 4'd0;
            frame_start <= 1'b0;
            nz          <= 1'b0;
            dark        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            digit_val   <= val_d;
            frame_start <= fs_d;
            nz          <= nz_d;
            dark        <= dark_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        idx_d   = idx;
        val_d   = digit_val;
        fs_d    = 1'b0;
        nz_d    = nz;
        dark_d  = dark;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = IDX_TOP;
            val_d   = 4'd0;
            nz_d    = 1'b0;
            dark_d  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    fs_d    = 1'b1;
                    nz_d    = 1'b0;
                end
                S_BLANK: if (cnt == BLANK_LAST) begin
                    state_d = S_SHOW;
                    val_d   = mux_f;
                    nz_d    = nz | (mux_f != 4'd0);
`ifdef DIGIT_SCAN_LZB_EN
                    dark_d  = (mux_f == 4'd0) && !nz && (idx != 3'd0);
`endif
                end
                S_SHOW: if (cnt == CNT_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx == 3'd0) ? IDX_TOP : idx - 3'd1;
                    // Wrapping past digit 0 starts a new frame.
                    fs_d    = (idx == 3'd0);
                    nz_d    = (idx == 3'd0) ? 1'b0 : nz;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign lit         = (state == S_SHOW) && !dark;
    assign digit_valid = lit;
    assign an_n        = lit ? ~(8'b1 << idx) : 8'hFF;
    assign sel         = (state == S_IDLE) ? 3'd0 : idx;
    assign mux_s2      = ~sel[2];
    assign mux_s1      = sel[1];
    assign mux_s0      = sel[0];
endmodule
